burst_frame_streamer: RTL and testbench
=======================================

# burst_frame_streamer

Sequencer directly downstream of the 8-word Avalon-MM burst read master. It walks a frame in DDR burst by burst, handshakes each burst with the read master, drains that master's on-chip buffer through its readback port, and emits the words as an Avalon-ST stream with start/end-of-frame markers and backpressure. It feeds the pixel pipeline and owns the read master's control inputs.

## Interface
- ADDRESS_WIDTH, 32, byte address width
- DATA_WIDTH, 32, word width
- BURST_LEN, 8, words per burst; must equal the read master's fixed burst
- BURST_WIDTH, 4, width of word index and burst count; holds BURST_LEN
- BYTES_PER_WORD, 4, address stride per word
- NBURST_WIDTH, 16, width of the frame burst-count field

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- start  in  1  one-cycle frame request, sampled only in IDLE
- stop  in  1  level; ends the frame at the next burst boundary
- frame_base  in  ADDRESS_WIDTH  byte address of the first burst
- frame_nbursts  in  NBURST_WIDTH  bursts per frame; 0 treated as 1
- busy  out  1  high from accepted start until return to IDLE
- frame_done  out  1  one-cycle pulse after the last word of a frame is accepted
- rd_start  out  1  to read master ctrl_start
- rd_baseaddress  out  ADDRESS_WIDTH  to read master ctrl_baseaddress
- rd_burstcount  out  BURST_WIDTH  constant BURST_LEN
- rd_busy  in  1  from read master ctrl_busy
- rd_readdatavalid  in  1  from read master; burst buffered, held until rd_start falls
- rd_address  out  BURST_WIDTH  buffer readback index
- rd_readdata  in  DATA_WIDTH  buffer q, one-cycle registered latency
- st_data  out  DATA_WIDTH  stream word
- st_valid  out  1  stream valid
- st_ready  in  1  stream ready
- st_sop  out  1  with the first word of a frame
- st_eop  out  1  with the last word of a frame

## Operation
- Reset values: busy, frame_done, rd_start, st_valid, st_sop, st_eop = 0; rd_address, rd_baseaddress, st_data = 0; rd_burstcount = BURST_LEN. Internal state returns to IDLE.
- States are IDLE, REQ, WAIT_DONE, RELEASE, and DRAIN.
- IDLE: on start, latch frame_base into addr_reg and max(frame_nbursts,1) into a remaining-burst counter; set busy; go to REQ.
- REQ: drive rd_baseaddress=addr_reg and rd_start=1; go to WAIT_DONE.
- WAIT_DONE: hold rd_start=1 until rd_readdatavalid=1. Then drop rd_start and go to RELEASE.
- RELEASE: wait for rd_readdatavalid=0, which means the master is back in its start state. Clear the word index and go to DRAIN.
- DRAIN: issue rd_address=0..BURST_LEN-1. The returned word lands in a 2-entry output skid FIFO.
  - Issue an address only when FIFO occupancy plus outstanding reads is less than 2.
  - The FIFO head drives st_data and st_valid. An entry pops on st_valid&&st_ready.
- Burst end: when the last word of the burst pops, decrement the remaining-burst counter and add BURST_LEN*BYTES_PER_WORD to addr_reg, modulo 2^ADDRESS_WIDTH (wraps silently).
  - If bursts remain and stop=0: go to REQ.
  - Otherwise: pulse frame_done and go to IDLE, with busy=0 on the same edge.
- st_sop is set on the first word of the first burst. st_eop is set on the last word of the final burst, or of the current burst when stop ends the frame early.
- stop during DRAIN sets a sticky flag and the burst completes normally. stop in IDLE has no effect.
- start while busy=1 is ignored.
- Stream rule: st_data, st_sop and st_eop stay stable while st_valid=1 and st_ready=0.
- rd_busy is informational only. If rd_busy=1 in IDLE or REQ, stay in REQ, hold rd_start=0, and wait.

## Timing
- rd_start rises 1 cycle after the start edge.
- The first rd_address is issued the cycle after rd_readdatavalid is sampled low.
- With st_ready held at 1, the first st_valid appears 2 cycles after the first rd_address (1 cycle of RAM latency, 1 cycle of FIFO register). After that, one word per cycle.
- Per-burst overhead is handshake + master latency + 3 cycles.
- Reset mid-frame: the stream is abandoned with no eop, and rd_start drops immediately. The read master is reset by the same reset.

## Configuration
- BURST_FRAME_STREAMER_LOOP_EN defined: at frame end, pulse frame_done, reload addr_reg from the latched base and the counter from the latched count, and go to REQ. busy stays 1, and the next frame's first word carries st_sop. Only stop ends the looping, at a burst boundary. stop ends the frame with st_eop, pulses frame_done and returns to IDLE.
- Undefined: single frame per start, as described above.

## Test plan
- frame_base=0x39000000, frame_nbursts=2, st_ready=1: rd_baseaddress takes 0x39000000 then 0x39000020. 16 words are emitted in order, sop on word 0, eop on word 15, and frame_done pulses once.
- Same frame with st_ready toggling 1010… and then held low for 5 cycles mid-burst: no word is lost or duplicated, st_data is stable while stalled, and FIFO occupancy never exceeds 2.
- frame_nbursts=0: exactly one burst (8 words) is emitted with both sop and eop markers.
- frame_base=0xFFFFFFF0, frame_nbursts=2: the second rd_baseaddress is 0x00000010.
- stop asserted during word 3 of burst 1 of 4: burst 1 completes, eop is on its word 7, there is no further rd_start, and frame_done pulses. In the LOOP_EN build, 3 frames run back-to-back and then stop ends the run the same way.
- reset asserted in DRAIN: all outputs reach their reset values immediately. A subsequent start runs a clean frame.

Source files
------------

// File: rtl/burst_frame_streamer.sv
// burst_frame_streamer: walks a frame through the burst read master and
// streams its buffered words out as Avalon-ST with sop/eop markers.
// Ports: clk, reset (async, active-high); start/stop/frame_base/
// frame_nbursts request a frame; busy/frame_done report on it;
// rd_* drive the read master control and its buffer readback;
// st_* is the stream source (data/valid/ready/sop/eop).
// Build option: BURST_FRAME_STREAMER_LOOP_EN repeats the frame until stop.
module burst_frame_streamer #(
  parameter int ADDRESS_WIDTH  = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int BURST_LEN      = 8,
  parameter int BURST_WIDTH    = 4,
  parameter int BYTES_PER_WORD = 4,
  parameter int NBURST_WIDTH   = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     stop,
  input  logic [ADDRESS_WIDTH-1:0] frame_base,
  input  logic [NBURST_WIDTH-1:0]  frame_nbursts,
  output logic                     busy,
  output logic                     frame_done,
  output logic                     rd_start,
  output logic [ADDRESS_WIDTH-1:0] rd_baseaddress,
  output logic [BURST_WIDTH-1:0]   rd_burstcount,
  input  logic                     rd_busy,
  input  logic                     rd_readdatavalid,
  output logic [BURST_WIDTH-1:0]   rd_address,
  input  logic [DATA_WIDTH-1:0]    rd_readdata,
  output logic [DATA_WIDTH-1:0]    st_data,
  output logic                     st_valid,
  input  logic                     st_ready,
  output logic                     st_sop,
  output logic                     st_eop
);

  localparam logic [BURST_WIDTH-1:0] N_IDX =
    BURST_WIDTH'(BURST_LEN);
  localparam logic [BURST_WIDTH-1:0] LAST_IDX =
    BURST_WIDTH'(BURST_LEN - 1);
  localparam logic [ADDRESS_WIDTH-1:0] STRIDE =
    ADDRESS_WIDTH'(BURST_LEN * BYTES_PER_WORD);
  localparam logic [NBURST_WIDTH-1:0] ONE =
    NBURST_WIDTH'(1);

  typedef enum logic [2:0] {
    IDLE, REQ, WAIT_DONE, RELEASE, DRAIN
  } state_t;

  state_t state, state_nxt;

  logic [ADDRESS_WIDTH-1:0] addr_reg;
  logic [NBURST_WIDTH-1:0]  rem_reg;
`ifdef BURST_FRAME_STREAMER_LOOP_EN
  logic [ADDRESS_WIDTH-1:0] base_reg;
  logic [NBURST_WIDTH-1:0]  nb_reg;
`endif
  logic [NBURST_WIDTH-1:0]  nb_first;
  logic                     stop_flag;
  logic                     stop_now;
  logic                     sop_pend;
  logic [BURST_WIDTH-1:0]   idx;
  logic                     pend;
  logic                     pend_sop;
  logic                     pend_last;

  logic [1:0][DATA_WIDTH-1:0] fifo_data;
  logic [1:0]               fifo_sop;
  logic [1:0]               fifo_eop;
  logic [1:0]               fifo_last;
  logic                     wr_ptr;
  logic                     rd_ptr;
  logic [1:0]               count;
  logic [1:0]               occ;

  logic pop;
  logic issue;
  logic burst_end;
  logic frame_end;
  logic looping;

  assign rd_burstcount = N_IDX;
  assign rd_address    = idx;

  assign st_valid = (count != 2'd0);
  assign st_data  = fifo_data[rd_ptr];
  assign st_sop   = st_valid && fifo_sop[rd_ptr];
  assign st_eop   = st_valid && fifo_eop[rd_ptr];

  assign nb_first = (frame_nbursts == '0) ? ONE : frame_nbursts;
  assign stop_now = stop_flag || stop;

  // A pop this cycle frees its slot, so reads keep one word per cycle.
  assign pop   = st_valid && st_ready;
  assign occ   = count + {1'b0, pend} - {1'b0, pop};
  assign issue = (state == DRAIN) && (idx < N_IDX) &&
                 (occ < 2'd2);

  assign burst_end = pop && fifo_last[rd_ptr];
  assign frame_end = burst_end && fifo_eop[rd_ptr];

`ifdef BURST_FRAME_STREAMER_LOOP_EN
  assign looping = !stop_now;
`else
  assign looping = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:      if (start) state_nxt = REQ;
      REQ:       if (!rd_busy) state_nxt = WAIT_DONE;
      WAIT_DONE: if (rd_readdatavalid) state_nxt = RELEASE;
      RELEASE:   if (!rd_readdatavalid) state_nxt = DRAIN;
      DRAIN: begin
        if (frame_end) begin
          state_nxt = looping ? REQ : IDLE;
        end else if (burst_end) begin
          state_nxt = REQ;
        end
      end
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy           <= 1'b0;
      frame_done     <= 1'b0;
      rd_start       <= 1'b0;
      rd_baseaddress <= '0;
      addr_reg       <= '0;
      rem_reg        <= '0;
`ifdef BURST_FRAME_STREAMER_LOOP_EN
      base_reg       <= '0;
      nb_reg         <= '0;
`endif
      stop_flag      <= 1'b0;
      sop_pend       <= 1'b0;
      idx            <= '0;
      pend           <= 1'b0;
      pend_sop       <= 1'b0;
      pend_last      <= 1'b0;
      fifo_data      <= '0;
      fifo_sop       <= '0;
      fifo_eop       <= '0;
      fifo_last      <= '0;
      wr_ptr         <= 1'b0;
      rd_ptr         <= 1'b0;
      count          <= '0;
    end else begin
      frame_done <= 1'b0;
      stop_flag  <= (state != IDLE) && stop_now;

      if (state == IDLE && start) begin
        busy     <= 1'b1;
        addr_reg <= frame_base;
        rem_reg  <= nb_first;
        sop_pend <= 1'b1;
`ifdef BURST_FRAME_STREAMER_LOOP_EN
        base_reg <= frame_base;
        nb_reg   <= nb_first;
`endif
      end

      if (state == REQ && !rd_busy) begin
        rd_start       <= 1'b1;
        rd_baseaddress <= addr_reg;
      end

      if (state == WAIT_DONE && rd_readdatavalid) begin
        rd_start <= 1'b0;
      end

      if (state == RELEASE && !rd_readdatavalid) begin
        idx <= '0;
      end

      pend      <= issue;
      pend_sop  <= issue && sop_pend && (idx == '0);
      pend_last <= issue && (idx == LAST_IDX);
      if (issue) begin
        idx <= idx + BURST_WIDTH'(1);
        if (idx == '0) sop_pend <= 1'b0;
      end

      // eop is fixed at push so it never changes under a stall.
      if (pend) begin
        fifo_data[wr_ptr] <= rd_readdata;
        fifo_sop[wr_ptr]  <= pend_sop;
        fifo_last[wr_ptr] <= pend_last;
        fifo_eop[wr_ptr]  <= pend_last &&
                             (rem_reg == ONE || stop_now);
        wr_ptr <= !wr_ptr;
      end
      if (pop) rd_ptr <= !rd_ptr;
      count <= count + {1'b0, pend} - {1'b0, pop};

      if (burst_end) begin
        rem_reg  <= rem_reg - ONE;
        addr_reg <= addr_reg + STRIDE;
      end

      if (frame_end) begin
        frame_done <= 1'b1;
`ifdef BURST_FRAME_STREAMER_LOOP_EN
        if (looping) begin
          addr_reg <= base_reg;
          rem_reg  <= nb_reg;
          sop_pend <= 1'b1;
        end else begin
          busy <= 1'b0;
        end
`else
        busy <= 1'b0;
`endif
      end
    end
  end

endmodule

// File: tb/tb_burst_frame_streamer.sv
// tb_burst_frame_streamer: directed frames against a behavioural read
// master; checks word order, markers, burst addresses, stalls, reset.
module tb_burst_frame_streamer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [31:0] frame_base = '0;
  logic [15:0] frame_nbursts = '0;
  logic        busy;
  logic        frame_done;
  logic        rd_start;
  logic [31:0] rd_baseaddress;
  logic [3:0]  rd_burstcount;
  logic        rd_busy;
  logic        rd_readdatavalid;
  logic [3:0]  rd_address;
  logic [31:0] rd_readdata;
  logic [31:0] st_data;
  logic        st_valid;
  logic        st_ready = 1'b1;
  logic        st_sop;
  logic        st_eop;

  burst_frame_streamer dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .stop             (stop),
    .frame_base       (frame_base),
    .frame_nbursts    (frame_nbursts),
    .busy             (busy),
    .frame_done       (frame_done),
    .rd_start         (rd_start),
    .rd_baseaddress   (rd_baseaddress),
    .rd_burstcount    (rd_burstcount),
    .rd_busy          (rd_busy),
    .rd_readdatavalid (rd_readdatavalid),
    .rd_address       (rd_address),
    .rd_readdata      (rd_readdata),
    .st_data          (st_data),
    .st_valid         (st_valid),
    .st_ready         (st_ready),
    .st_sop           (st_sop),
    .st_eop           (st_eop)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Read master model: fills its buffer with word byte addresses.
  logic [31:0] mbuf [8];
  logic        mact;
  int          mcnt;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_busy          <= 1'b0;
      rd_readdatavalid <= 1'b0;
      mact             <= 1'b0;
      mcnt             <= 0;
    end else if (!mact) begin
      if (rd_start) begin
        mact    <= 1'b1;
        rd_busy <= 1'b1;
        mcnt    <= 3;
        for (int i = 0; i < 8; i++)
          mbuf[i] <= rd_baseaddress + 32'(4 * i);
      end
    end else if (!rd_readdatavalid) begin
      if (mcnt == 0) rd_readdatavalid <= 1'b1;
      else mcnt <= mcnt - 1;
    end else if (!rd_start) begin
      rd_readdatavalid <= 1'b0;
      rd_busy          <= 1'b0;
      mact             <= 1'b0;
    end
  end

  always @(posedge clk) rd_readdata <= mbuf[rd_address[2:0]];

  // Monitor
  logic [31:0] wd [$];
  bit          ws [$];
  bit          we [$];
  logic [31:0] bases [$];
  int          dones = 0;
  logic        rs_q = 1'b0;
  bit          stalled = 1'b0;
  logic [33:0] held = '0;

  always @(negedge clk) begin
    if (reset) begin
      rs_q    = 1'b0;
      stalled = 1'b0;
    end else begin
      if (rd_start && !rs_q) bases.push_back(rd_baseaddress);
      rs_q = rd_start;
      if (frame_done) dones++;
      if (stalled)
        chk("stall_hold", {st_valid, st_sop, st_eop, st_data},
            {1'b1, held});
      if (st_valid && st_ready) begin
        wd.push_back(st_data);
        ws.push_back(st_sop);
        we.push_back(st_eop);
      end
      stalled = st_valid && !st_ready;
      held    = {st_sop, st_eop, st_data};
    end
  end

  // Ready driver: mode 1 toggles and inserts one 5-cycle stall.
  int cyc = 0;
  bit rmode = 1'b0;
  bit stall_done = 1'b0;
  int stall_left = 0;

  always @(posedge clk) begin
    #1;
    cyc++;
    if (rmode && !stall_done && wd.size() == 3) begin
      stall_left = 5;
      stall_done = 1'b1;
    end
    if (!rmode) begin
      st_ready = 1'b1;
    end else if (stall_left > 0) begin
      st_ready = 1'b0;
      stall_left--;
    end else begin
      st_ready = cyc[0];
    end
  end

  task automatic clear_mon();
    wd.delete();
    ws.delete();
    we.delete();
    bases.delete();
    dones = 0;
  endtask

  task automatic pulse_start(input logic [31:0] base,
                             input logic [15:0] nb);
    frame_base    = base;
    frame_nbursts = nb;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic check_words(input string tag,
                             input logic [31:0] base,
                             input int n, input int flen);
    logic [31:0] ed;
    chk({tag, "_count"}, wd.size(), n);
    for (int k = 0; k < n && k < wd.size(); k++) begin
      ed = base + 32'(4 * (k % flen));
      chk($sformatf("%s_w%0d", tag, k),
          {ws[k], we[k], wd[k]},
          {(k % flen == 0), (k % flen == flen - 1), ed});
    end
  endtask

  task automatic run_frame(input string tag,
                           input logic [31:0] base,
                           input logic [15:0] nb,
                           input bit stop3,
                           input int exp_bursts);
    clear_mon();
    pulse_start(base, nb);
    chk({tag, "_busy_on"}, busy, 1);
    chk({tag, "_rs_early"}, rd_start, 0);
    @(posedge clk); #1;
    chk({tag, "_rs_rise"}, rd_start, 1);
    for (int i = 0; i < 3000 && dones == 0; i++) begin
      @(posedge clk); #1;
      if (stop3 && wd.size() >= 4) stop = 1'b1;
    end
    chk({tag, "_busy_off"}, busy, 0);
    stop = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk({tag, "_dones"}, dones, 1);
    chk({tag, "_bursts"}, bases.size(), exp_bursts);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ctl", {busy, frame_done, rd_start,
                    st_valid, st_sop, st_eop}, 0);
    chk("rst_addr", rd_address, 0);
    chk("rst_base", rd_baseaddress, 0);
    chk("rst_data", st_data, 0);
    chk("rst_bcount", rd_burstcount, 8);
    reset = 1'b0;
    repeat (2) @(posedge clk);

`ifdef BURST_FRAME_STREAMER_LOOP_EN
    clear_mon();
    pulse_start(32'h0000_3000, 16'd1);
    for (int i = 0; i < 3000 && dones < 3; i++) begin
      @(posedge clk); #1;
    end
    stop = 1'b1;
    for (int i = 0; i < 3000 && busy; i++) begin
      @(posedge clk); #1;
    end
    chk("loop_busy_off", busy, 0);
    stop = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("loop_dones", dones, 4);
    chk("loop_bursts", bases.size(), 4);
    check_words("loop", 32'h0000_3000, 32, 8);
`else
    run_frame("a", 32'h3900_0000, 16'd2, 1'b0, 2);
    chk("a_base0", bases[0], 32'h3900_0000);
    chk("a_base1", bases[1], 32'h3900_0020);
    check_words("a", 32'h3900_0000, 16, 16);

    rmode = 1'b1;
    stall_done = 1'b0;
    run_frame("b", 32'h3900_0000, 16'd2, 1'b0, 2);
    rmode = 1'b0;
    check_words("b", 32'h3900_0000, 16, 16);

    run_frame("c", 32'h0040_0000, 16'd0, 1'b0, 1);
    check_words("c", 32'h0040_0000, 8, 8);

    run_frame("d", 32'hFFFF_FFF0, 16'd2, 1'b0, 2);
    chk("d_base1", bases[1], 32'h0000_0010);
    check_words("d", 32'hFFFF_FFF0, 16, 16);

    run_frame("s", 32'h0000_1000, 16'd4, 1'b1, 1);
    check_words("s", 32'h0000_1000, 8, 8);
`endif

    clear_mon();
    pulse_start(32'h0000_5000, 16'd2);
    for (int i = 0; i < 500 && wd.size() < 3; i++) begin
      @(posedge clk); #1;
    end
    chk("rr_in_drain", wd.size() >= 3, 1);
    #2 reset = 1'b1;
    #1;
    chk("rr_ctl", {busy, frame_done, rd_start,
                   st_valid, st_sop, st_eop}, 0);
    chk("rr_addr", rd_address, 0);
    chk("rr_base", rd_baseaddress, 0);
    chk("rr_data", st_data, 0);
    chk("rr_bcount", rd_burstcount, 8);
    @(posedge clk); #1 reset = 1'b0;
    repeat (2) @(posedge clk);

    run_frame("post", 32'h0000_2000, 16'd1, 1'b1, 1);
    check_words("post", 32'h0000_2000, 8, 8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
